uart_drv_param: RTL



---
 rtl/uart_drv_pkg.sv | 20 ++
 rtl/uart_drv_fifo.sv | 59 +++++
 rtl/uart_drv_param.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_drv_pkg.sv
// Shared constants and state types for the parametrised UART driver.
// Parity modes, FSM state encodings and rxerr bit positions live here.
package uart_drv_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int RXERR_FRAME  = 0;
  localparam int RXERR_PARITY = 1;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_drv_fifo.sv
// Single-clock synchronous FIFO buffering words waiting to be transmitted.
// Read data is registered on pop and held until the next pop.
module uart_drv_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_dout;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_dout  = r_dout;

  // Storage carries no reset so it maps onto RAM primitives.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dout   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_dout   <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_drv_param.sv
// UART bus-functional driver: buffered transmitter and error-reporting receiver
// with configurable bit rate, data width, parity and stop bits.
module uart_drv_param
  import uart_drv_pkg::*;
#(
  parameter int CLKS_PER_BIT  = 434,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int TX_FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 rx,
  output logic                 tx,
  input  logic                 txrdy,
  input  logic [DATA_BITS-1:0] txdata,
  output logic                 txack,
  output logic                 txidle,
  output logic                 rxrdy,
  output logic [DATA_BITS-1:0] rxdata,
  output logic [1:0]           rxerr
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic             PAR_EN    = (PARITY != PAR_NONE);
  localparam logic             PAR_ODD_B = (PARITY == PAR_ODD);

  // ---------------- TX path ----------------
  logic                 w_accept, w_pop, w_full, w_empty, w_tx_tick;
  logic [DATA_BITS-1:0] w_fifo_dout;
  logic                 r_txack, r_txidle;

  tx_state_e            r_tx_state, w_tx_state_next;
  logic [CNT_W-1:0]     r_tx_cnt, w_tx_cnt_next;
  logic [3:0]           r_tx_bit, w_tx_bit_next;
  logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_next;
  logic                 r_tx_par, w_tx_par_next;

  assign w_accept  = txrdy && !w_full && !r_txack;
  assign w_tx_tick = (r_tx_cnt == LAST_CNT);
  assign txack     = r_txack;
  assign txidle    = r_txidle;

  uart_drv_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .nreset  (nreset),
    .i_push  (w_accept),
    .i_din   (txdata),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_txack    <= 1'b0;
      r_txidle   <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_next;
      r_tx_cnt   <= w_tx_cnt_next;
      r_tx_bit   <= w_tx_bit_next;
      r_tx_shift <= w_tx_shift_next;
      r_tx_par   <= w_tx_par_next;
      r_txack    <= w_accept;
      r_txidle   <= (r_tx_state == TX_IDLE) && w_empty && !w_accept;
    end
  end

  // The popped word lands in the FIFO read register during START and is loaded at its end.
  always_comb begin
    w_tx_state_next = r_tx_state;
    w_tx_cnt_next   = w_tx_tick ? '0 : r_tx_cnt + CNT_W'(1);
    w_tx_bit_next   = r_tx_bit;
    w_tx_shift_next = r_tx_shift;
    w_tx_par_next   = r_tx_par;
    w_pop           = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_cnt_next = '0;
        if (!w_empty) begin
          w_pop           = 1'b1;
          w_tx_state_next = TX_START;
        end
      end
      TX_START: if (w_tx_tick) begin
        w_tx_state_next = TX_DATA;
        w_tx_bit_next   = '0;
        w_tx_shift_next = w_fifo_dout;
        w_tx_par_next   = (^w_fifo_dout) ^ PAR_ODD_B;
      end
      TX_DATA: if (w_tx_tick) begin
        if (r_tx_bit == LAST_DATA) begin
          w_tx_state_next = PAR_EN ? TX_PARITY : TX_STOP;
          w_tx_bit_next   = '0;
        end else begin
          w_tx_bit_next   = r_tx_bit + 4'd1;
          w_tx_shift_next = r_tx_shift >> 1;
        end
      end
      TX_PARITY: if (w_tx_tick) begin
        w_tx_state_next = TX_STOP;
        w_tx_bit_next   = '0;
      end
      TX_STOP: if (w_tx_tick) begin
        if (r_tx_bit == LAST_STOP) begin
          if (!w_empty) begin
            w_pop           = 1'b1;
            w_tx_state_next = TX_START;
          end else begin
            w_tx_state_next = TX_IDLE;
          end
        end else begin
          w_tx_bit_next = r_tx_bit + 4'd1;
        end
      end
      default: w_tx_state_next = TX_IDLE;
    endcase
  end

  always_comb begin
    case (r_tx_state)
      TX_START:  tx = 1'b0;
      TX_DATA:   tx = r_tx_shift[0];
      TX_PARITY: tx = r_tx_par;
      default:   tx = 1'b1;
    endcase
  end

  // ---------------- RX path ----------------
  logic                 r_rx_meta, r_rx_sync, r_rx_prev, w_rx_fall, w_rx_tick;
  rx_state_e            r_rx_state, w_rx_state_next;
  logic [CNT_W-1:0]     r_rx_cnt, w_rx_cnt_next;
  logic [3:0]           r_rx_bit, w_rx_bit_next;
  logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift_next;
  logic                 r_rx_par, w_rx_par_next;
  logic                 r_rx_perr, w_rx_perr_next;
  logic                 r_rxrdy, w_rxrdy_next;
  logic [DATA_BITS-1:0] r_rxdata, w_rxdata_next;
  logic [1:0]           r_rxerr, w_rxerr_next;

  assign w_rx_fall = r_rx_prev && !r_rx_sync;
  assign w_rx_tick = (r_rx_cnt == LAST_CNT);
  assign rxrdy     = r_rxrdy;
  assign rxdata    = r_rxdata;
  assign rxerr     = r_rxerr;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_par   <= 1'b0;
      r_rx_perr  <= 1'b0;
      r_rxrdy    <= 1'b0;
      r_rxdata   <= '0;
      r_rxerr    <= '0;
    end else begin
      r_rx_meta  <= rx;
      r_rx_sync  <= r_rx_meta;
      r_rx_prev  <= r_rx_sync;
      r_rx_state <= w_rx_state_next;
      r_rx_cnt   <= w_rx_cnt_next;
      r_rx_bit   <= w_rx_bit_next;
      r_rx_shift <= w_rx_shift_next;
      r_rx_par   <= w_rx_par_next;
      r_rx_perr  <= w_rx_perr_next;
      r_rxrdy    <= w_rxrdy_next;
      r_rxdata   <= w_rxdata_next;
      r_rxerr    <= w_rxerr_next;
    end
  end

  // After the half-bit check in START every sample falls mid-bit.
  always_comb begin
    w_rx_state_next = r_rx_state;
    w_rx_cnt_next   = r_rx_cnt + CNT_W'(1);
    w_rx_bit_next   = r_rx_bit;
    w_rx_shift_next = r_rx_shift;
    w_rx_par_next   = r_rx_par;
    w_rx_perr_next  = r_rx_perr;
    w_rxrdy_next    = 1'b0;
    w_rxdata_next   = r_rxdata;
    w_rxerr_next    = r_rxerr;
    case (r_rx_state)
      RX_IDLE: begin
        w_rx_cnt_next = '0;
        if (w_rx_fall) w_rx_state_next = RX_START;
      end
      RX_START: if (r_rx_cnt == HALF_CNT) begin
        w_rx_cnt_next = '0;
        if (r_rx_sync) begin
          w_rx_state_next = RX_IDLE;
        end else begin
          w_rx_state_next = RX_DATA;
          w_rx_bit_next   = '0;
          w_rx_par_next   = 1'b0;
          w_rx_perr_next  = 1'b0;
        end
      end
      RX_DATA: if (w_rx_tick) begin
        w_rx_cnt_next   = '0;
        w_rx_shift_next = {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
        w_rx_par_next   = r_rx_par ^ r_rx_sync;
        if (r_rx_bit == LAST_DATA) w_rx_state_next = PAR_EN ? RX_PARITY : RX_STOP;
        else                       w_rx_bit_next   = r_rx_bit + 4'd1;
      end
      RX_PARITY: if (w_rx_tick) begin
        w_rx_cnt_next   = '0;
        w_rx_perr_next  = ((r_rx_par ^ r_rx_sync) != PAR_ODD_B);
        w_rx_state_next = RX_STOP;
      end
      RX_STOP: if (w_rx_tick) begin
        w_rx_cnt_next              = '0;
        w_rx_state_next            = RX_IDLE;
        w_rxrdy_next               = 1'b1;
        w_rxdata_next              = r_rx_shift;
        w_rxerr_next[RXERR_FRAME]  = !r_rx_sync;
        w_rxerr_next[RXERR_PARITY] = r_rx_perr;
      end
      default: w_rx_state_next = RX_IDLE;
    endcase
  end

endmodule
